// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial wide adder: one 4-bit ripple adder is time-multiplexed over
// NIBBLES slices, with valid/ready handshakes on the operand and result sides.

// 4-bit ripple-carry adder built from explicit full-adder equations.
module fourbit_fulladd (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry_s;

  // Ripple the carry through four full-adder cells.
  always_comb begin
    carry_s    = 5'b00000;
    sum        = 4'b0000;
    carry_s[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
    end
    c_out = carry_s[4];
  end

endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [IW+1:0]   shamt_s;
  logic [3:0]      a_nib_s;
  logic [3:0]      b_nib_s;
  logic [3:0]      add_sum_s;
  logic            add_co_s;
  logic [W-1:0]    nib_mask_s;
  logic [W-1:0]    nib_sum_s;

  // Select the current operand nibbles and place the adder result in its slot.
  always_comb begin
    shamt_s    = {idx_q, 2'b00};
    a_nib_s    = 4'(a_q >> shamt_s);
    b_nib_s    = 4'(b_q >> shamt_s);
    nib_mask_s = W'(4'hF) << shamt_s;
    nib_sum_s  = W'(add_sum_s) << shamt_s;
  end

  fourbit_fulladd u_add (
    .a     (a_nib_s),
    .b     (b_nib_s),
    .c_in  (carry_q),
    .sum   (add_sum_s),
    .c_out (add_co_s)
  );

  // Next-state and datapath update; outputs are decoded from the next state
  // so that the registered handshake signals are a pure function of state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = {IW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d   = (sum_q & ~nib_mask_s) | nib_sum_s;
        carry_d = add_co_s;
        if (idx_q == LAST_IDX) begin
          c_out_d = add_co_s;
          idx_d   = {IW{1'b0}};
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  // State, datapath and output registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      carry_q     <= 1'b0;
      idx_q       <= {IW{1'b0}};
      sum_q       <= {W{1'b0}};
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (NIBBLES=4 and 1).
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        iv4, ir4, ci4, ov4, or4, co4, bz4;
  logic [15:0] a4, b4, s4;
  logic        iv1, ir1, ci1, ov1, or1, co1, bz1;
  logic [3:0]  a1, b1, s1;

  int n_assert = 0;
  int n_fail   = 0;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .c_in(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .c_out(co4), .busy(bz4)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .c_in(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1), .c_out(co1), .busy(bz1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full NIBBLES=4 transaction with latency, result and release checks.
  task automatic op4(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                     input logic [15:0] es, input logic ec, input string tag);
    int lat;
    lat = 0;
    a4 = av; b4 = bv; ci4 = cv; iv4 = 1'b1;
    step();
    iv4 = 1'b0; a4 = 16'hDEAD; b4 = 16'hBEEF; ci4 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ov4) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(s4), 64'(es));
    chk({tag, "_cout"}, 64'(co4), 64'(ec));
    chk({tag, "_inrdy_done"}, 64'(ir4), 64'd0);
    chk({tag, "_busy_done"}, 64'(bz4), 64'd1);
    or4 = 1'b1;
    step();
    or4 = 1'b0;
    chk({tag, "_ov_drop"}, 64'(ov4), 64'd0);
    chk({tag, "_inrdy_back"}, 64'(ir4), 64'd1);
    chk({tag, "_busy_idle"}, 64'(bz4), 64'd0);
  endtask

  logic [15:0] bs_a [3];
  logic [15:0] bs_b [3];
  logic        bs_c [3];
  logic [15:0] rs_s [3];
  logic        rs_c [3];
  int          rs_t [3];

  initial begin
    int nacc, nres, seen;
    logic rdy;
    logic [4:0] e5;

    rst = 1'b1;
    iv4 = 1'b0; a4 = 16'h0; b4 = 16'h0; ci4 = 1'b0; or4 = 1'b0;
    iv1 = 1'b0; a1 = 4'h0;  b1 = 4'h0;  ci1 = 1'b0; or1 = 1'b0;
    step();
    step();
    chk("rst_inrdy", 64'(ir4), 64'd1);
    chk("rst_ov", 64'(ov4), 64'd0);
    chk("rst_busy", 64'(bz4), 64'd0);
    chk("rst_sum", 64'(s4), 64'd0);
    chk("rst_cout", 64'(co4), 64'd0);
    rst = 1'b0;

    // Test 1 and 2: basic adds and full carry propagation
    op4(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "t1_zero");
    op4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "t2_ripple");
    op4(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "t2_allones");

    // Test 3: back-pressure in DONE, ignored second operand set
    a4 = 16'h1234; b4 = 16'h4321; ci4 = 1'b0; iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ov4) begin
        seen = k;
        break;
      end
    end
    chk("t3_lat", 64'(seen), 64'd4);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        iv4 = 1'b1; a4 = 16'h1111; b4 = 16'h1111;
      end else begin
        iv4 = 1'b0;
      end
      step();
      chk("t3_hold_sum", 64'(s4), 64'h5555);
      chk("t3_hold_cout", 64'(co4), 64'd0);
      chk("t3_hold_ov", 64'(ov4), 64'd1);
      chk("t3_hold_inrdy", 64'(ir4), 64'd0);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    step();
    or4 = 1'b0;
    chk("t3_release_inrdy", 64'(ir4), 64'd1);
    chk("t3_release_ov", 64'(ov4), 64'd0);

    // Test 4: back-to-back with in_valid and out_ready held high
    bs_a[0] = 16'h0F0F; bs_b[0] = 16'h00F1; bs_c[0] = 1'b0;
    bs_a[1] = 16'h8000; bs_b[1] = 16'h8000; bs_c[1] = 1'b0;
    bs_a[2] = 16'h7FFF; bs_b[2] = 16'h0000; bs_c[2] = 1'b1;
    nacc = 0; nres = 0;
    a4 = bs_a[0]; b4 = bs_b[0]; ci4 = bs_c[0];
    iv4 = 1'b1; or4 = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      rdy = ir4;
      step();
      if (rdy && iv4) begin
        nacc++;
        if (nacc < 3) begin
          a4 = bs_a[nacc]; b4 = bs_b[nacc]; ci4 = bs_c[nacc];
        end else begin
          iv4 = 1'b0;
        end
      end
      if (ov4 && nres < 3) begin
        rs_s[nres] = s4; rs_c[nres] = co4; rs_t[nres] = cyc;
        nres++;
      end
      if (nres == 3) break;
    end
    chk("t4_count", 64'(nres), 64'd3);
    if (nres == 3) begin
      chk("t4_r0_sum", 64'(rs_s[0]), 64'h1000);
      chk("t4_r0_cout", 64'(rs_c[0]), 64'd0);
      chk("t4_r1_sum", 64'(rs_s[1]), 64'h0000);
      chk("t4_r1_cout", 64'(rs_c[1]), 64'd1);
      chk("t4_r2_sum", 64'(rs_s[2]), 64'h8000);
      chk("t4_r2_cout", 64'(rs_c[2]), 64'd0);
      chk("t4_gap01", 64'(rs_t[1] - rs_t[0]), 64'd6);
      chk("t4_gap12", 64'(rs_t[2] - rs_t[1]), 64'd6);
    end
    iv4 = 1'b0;
    step();
    or4 = 1'b0;
    chk("t4_idle_inrdy", 64'(ir4), 64'd1);

    // Test 5: reset in the middle of RUN aborts the operation
    a4 = 16'hFFFF; b4 = 16'h0001; ci4 = 1'b0; iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_inrdy", 64'(ir4), 64'd1);
    chk("t5_rst_ov", 64'(ov4), 64'd0);
    chk("t5_rst_busy", 64'(bz4), 64'd0);
    chk("t5_rst_sum", 64'(s4), 64'd0);
    chk("t5_rst_cout", 64'(co4), 64'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ov4) seen = 1;
    end
    chk("t5_no_result", 64'(seen), 64'd0);
    op4(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "t5_after");

    // Test 6: NIBBLES=1 latency and exhaustive sweep
    a1 = 4'hF; b1 = 4'h1; ci1 = 1'b0; iv1 = 1'b1;
    step();
    iv1 = 1'b0;
    step();
    chk("t6_lat_ov", 64'(ov1), 64'd1);
    chk("t6_sum", 64'(s1), 64'h0);
    chk("t6_cout", 64'(co1), 64'd1);
    or1 = 1'b1;
    step();
    chk("t6_release_inrdy", 64'(ir1), 64'd1);
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a1 = 4'(ai); b1 = 4'(bi); ci1 = 1'(ci); iv1 = 1'b1;
          step();
          iv1 = 1'b0;
          step();
          e5 = 5'(ai + bi + ci);
          chk("t6_sweep", 64'({ov1, co1, s1}), 64'({1'b1, e5}));
          step();
        end
      end
    end
    or1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencing controller that computes wide additions by time-multiplexing a single 4-bit ripple adder (the existing fourbit_fulladd block) over successive nibbles.
- Holds the operands and the inter-nibble carry in registers.
- Presents one nibble per cycle to the adder and assembles the wide sum.
- Uses valid/ready handshakes on input and output.
- Sits between operand producers and consumers that need wide adds where area matters more than latency.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set a/b/c_in is valid
in_ready  output  1  controller can accept an operand set
a  input  W  operand A
b  input  W  operand B
c_in  input  1  carry into nibble 0
out_valid  output  1  sum/c_out valid
out_ready  input  1  consumer accepts result
sum  output  W  assembled sum, registered
c_out  output  1  carry out of the top nibble, registered
busy  output  1  high in RUN or DONE

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - sum = 0, c_out = 0, nibble index = 0, carry register = 0, operand registers = 0.
- Exactly one fourbit_fulladd instance in the datapath.
  - Inputs: A nibble [idx], B nibble [idx], carry register.
  - No other adder logic is permitted.
- Nibble index width is clog2(NIBBLES), minimum 1 bit.
- FSM, three states:
  - IDLE:
    - in_ready = 1, out_valid = 0.
    - On an edge with in_valid = 1: latch a, b; carry register <= c_in; idx <= 0; go to RUN.
    - in_valid = 0: stay in IDLE.
  - RUN:
    - in_ready = 0; in_valid is ignored.
    - Each edge: sum[4*idx+3:4*idx] <= adder sum; carry register <= adder carry-out; idx <= idx+1.
    - On the edge where idx == NIBBLES-1: c_out <= adder carry-out, idx <= 0, go to DONE.
  - DONE:
    - out_valid = 1; sum and c_out are held stable while out_ready = 0.
    - On an edge with out_ready = 1: go to IDLE. out_valid drops and in_ready rises in the following cycle; there is no same-cycle re-accept.
- Latency:
  - Accept at edge E0 → out_valid high from edge E0+NIBBLES.
  - With out_ready tied high, throughput is one operation per NIBBLES+2 cycles.
- Sum nibbles not yet written in RUN retain their previous values. The consumer sees sum only when out_valid = 1.
- Arithmetic:
  - {c_out, sum} = a + b + c_in, exact for all W-bit unsigned operands.
  - Wrap-around beyond W bits is reported only via c_out.
- Input changes on a, b or c_in after acceptance have no effect on the result in progress.
- in_ready and out_valid are decoded purely from state (Moore). There are no combinational paths from in_valid or out_ready.
- Reset in any state, including mid-RUN or in DONE with out_valid = 1:
  - The operation is aborted and no result is emitted.
  - All outputs return to reset values on the next edge.
  - rst has priority over in_valid and out_ready.
- NIBBLES = 1: RUN lasts one cycle; latency is 1.

Test Plan:
1. NIBBLES=4. a=0x0000, b=0x0000, c_in=0 → sum=0x0000, c_out=0; out_valid rises exactly 4 cycles after the accept edge.
2. a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1 (carry propagates through all nibbles). Then a=0xFFFF, b=0xFFFF, c_in=1 → sum=0xFFFF, c_out=1.
3. a=0x1234, b=0x4321, c_in=0, out_ready held low 5 cycles in DONE:
   - sum=0x5555, c_out=0 stable throughout; in_ready=0.
   - A second in_valid pulse with a=0x1111 is ignored.
   - After out_ready=1: in_ready=1 one cycle later.
4. Back-to-back: in_valid and out_ready held high with three operand sets (0x0F0F+0x00F1, 0x8000+0x8000, 0x7FFF+0x0000 c_in=1):
   - Results 0x1000/0, 0x0000/1, 0x8000/0.
   - Each result 6 cycles apart.
5. rst asserted for one cycle at the second RUN cycle of a=0xFFFF+0x0001:
   - out_valid never rises; outputs return to reset values; in_ready=1 after reset.
   - A following 0x00FF+0x0001 yields 0x0100/0.
6. NIBBLES=1: a=0xF, b=0x1, c_in=0 → sum=0x0, c_out=1, latency 1 cycle. Exhaustive 512-case sweep of a, b, c_in matches a+b+c_in.
